pwm_modulator: RTL and testbench

PWM_MODULATOR -- requirements
Module: pwm_modulator

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_prescaler.sv | 29 ++
 rtl/pwm_modulator.sv | 122 ++++++++++++
 tb/tb_pwm_modulator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths, period length and FSM state type for the PWM modulator
package pwm_pkg;

    localparam int CNT_W  = 7;
    localparam int PERIOD = 128;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - divides sysclk into PWM count ticks, held at zero while clear is high
module pwm_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    logic [7:0] count_q, count_d;

    always_comb begin
        tick    = !clear && (count_q == 8'(PRESCALE - 1));
        count_d = count_q + 8'd1;
        if (clear || tick) begin
            count_d = 8'd0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pwm_modulator.sv
// rtl/pwm_modulator.sv - 128-count PWM with period-latched duty; PWM_DEADTIME_EN adds complementary output with dead time
module pwm_modulator
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE    = 1,
    parameter int unsigned DEAD_CYCLES = 4
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] duty,
    output logic             pwm_out,
    output logic             pwm_n,
    output logic             period_start
);

    pwm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic             new_period_q, new_period_d;
    logic             pwm_out_q, pwm_out_d;
    logic             pwm_n_q, pwm_n_d;
    logic             period_start_q, period_start_d;
    logic             tick, run, wrap, raw;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .sysclk (sysclk),
        .reset  (reset),
        .clear  (!run),
        .tick   (tick)
    );

    always_comb begin
        run   = (state_q == RUN);
        wrap  = run && tick && (cnt_q == CNT_W'(PERIOD - 1));
        raw   = run && (cnt_q < duty_sh_q);

        state_d = state_q;
        if (!run && enable) begin
            state_d = RUN;
        end else if (run && !enable) begin
            state_d = IDLE;
        end

        cnt_d = '0;
        if (run) begin
            cnt_d = tick ? cnt_q + 7'd1 : cnt_q;
        end

        // Duty is only sampled at a period boundary so a period is never split
        duty_sh_d      = (!run || wrap) ? duty : duty_sh_q;
        new_period_d   = !run || wrap;
        period_start_d = run && new_period_q;
    end

`ifdef PWM_DEADTIME_EN
    localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYCLES - 1);

    logic       raw_prev_q, raw_prev_d;
    logic [3:0] dead_q, dead_d;
    logic       raw_edge, dead_active;

    always_comb begin
        raw_prev_d  = raw;
        raw_edge    = raw ^ raw_prev_q;
        dead_active = raw_edge || (dead_q != 4'd0);
        dead_d      = dead_q;
        if (raw_edge) begin
            dead_d = DEAD_LOAD;
        end else if (dead_q != 4'd0) begin
            dead_d = dead_q - 4'd1;
        end
        pwm_out_d = raw && !dead_active;
        pwm_n_d   = run && !raw && !dead_active;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            raw_prev_q <= 1'b0;
            dead_q     <= 4'd0;
        end else begin
            raw_prev_q <= raw_prev_d;
            dead_q     <= dead_d;
        end
    end
`else
    logic unused_dead_cfg;
    assign unused_dead_cfg = ^4'(DEAD_CYCLES);

    always_comb begin
        pwm_out_d = raw;
        pwm_n_d   = 1'b0;
    end
`endif

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            duty_sh_q      <= '0;
            new_period_q   <= 1'b0;
            pwm_out_q      <= 1'b0;
            pwm_n_q        <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            duty_sh_q      <= duty_sh_d;
            new_period_q   <= new_period_d;
            pwm_out_q      <= pwm_out_d;
            pwm_n_q        <= pwm_n_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign pwm_n        = pwm_n_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_modulator.sv
// tb/tb_pwm_modulator.sv - directed self-checking bench for pwm_modulator (PRESCALE 1 and 3 instances)
module tb_pwm_modulator;
    import pwm_pkg::*;

`ifdef PWM_DEADTIME_EN
    localparam int DT = 4;
`else
    localparam int DT = 0;
`endif

    logic       sysclk;
    logic       reset, enable;
    logic [6:0] duty;
    logic       pwm_out, pwm_n, period_start;
    logic       reset3, enable3;
    logic [6:0] duty3;
    logic       pwm_out3, pwm_n3, period_start3;

    int checks = 0;
    int errors = 0;

    pwm_modulator #(.PRESCALE(1), .DEAD_CYCLES(4)) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .enable       (enable),
        .duty         (duty),
        .pwm_out      (pwm_out),
        .pwm_n        (pwm_n),
        .period_start (period_start)
    );

    pwm_modulator #(.PRESCALE(3), .DEAD_CYCLES(4)) dut3 (
        .sysclk       (sysclk),
        .reset        (reset3),
        .enable       (enable3),
        .duty         (duty3),
        .pwm_out      (pwm_out3),
        .pwm_n        (pwm_n3),
        .period_start (period_start3)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Leaves the bench at the sample showing count 0 of the first period
    task automatic start_run(input logic [6:0] d);
        duty   = d;
        enable = 1'b1;
        step();
        step();
    endtask

    task automatic measure(input bit use3, input int len, input int chg_at, input logic [6:0] chg_duty,
                           output int hi, output int hi_n, output int ps_cnt, output bit ps_first,
                           output bit last_out, output int first_hi, output int overlap);
        logic o, n, p;
        hi = 0; hi_n = 0; ps_cnt = 0; ps_first = 1'b0; last_out = 1'b0; first_hi = -1; overlap = 0;
        for (int i = 0; i < len; i++) begin
            o = use3 ? pwm_out3 : pwm_out;
            n = use3 ? pwm_n3 : pwm_n;
            p = use3 ? period_start3 : period_start;
            if (o) begin
                hi++;
                if (first_hi < 0) first_hi = i;
            end
            if (n) hi_n++;
            if (o && n) overlap++;
            if (p) begin
                ps_cnt++;
                if (i == 0) ps_first = 1'b1;
            end
            if (i == len - 1) last_out = o;
            if (i == chg_at) begin
                if (use3) duty3 = chg_duty;
                else duty = chg_duty;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        duty   = 7'd50;
        step();
        step();
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm_out: got %b expected 0", pwm_out); end
        checks++; if (pwm_n !== 1'b0) begin errors++; $display("FAIL reset_pwm_n: got %b expected 0", pwm_n); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_period_start: got %b expected 0", period_start); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_wins_state: got %0d expected IDLE", dut.state_q); end
        reset  = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++; if ({pwm_out, pwm_n, period_start} !== 3'b000) begin errors++; $display("FAIL idle_outputs: got %b expected 000", {pwm_out, pwm_n, period_start}); end
        checks++; if (dut.cnt_q !== 7'd0) begin errors++; $display("FAIL idle_cnt: got %0d expected 0", dut.cnt_q); end
    endtask

    task automatic test_basic();
        int hi, hi_n, ps_cnt, first_hi, overlap;
        bit ps_first, last_out;
        do_reset();
        start_run(7'd32);
        for (int p = 0; p < 2; p++) begin
            measure(1'b0, 128, -1, 7'd0, hi, hi_n, ps_cnt, ps_first, last_out, first_hi, overlap);
            checks++; if (hi !== 32 - DT) begin errors++; $display("FAIL basic_high_p%0d: got %0d expected %0d", p, hi, 32 - DT); end
            checks++; if (hi_n !== ((DT != 0) ? 96 - DT : 0)) begin errors++; $display("FAIL basic_pwm_n_p%0d: got %0d expected %0d", p, hi_n, (DT != 0) ? 96 - DT : 0); end
            checks++; if (first_hi !== DT) begin errors++; $display("FAIL basic_first_high_p%0d: got %0d expected %0d", p, first_hi, DT); end
            checks++; if (!ps_first || ps_cnt !== 1) begin errors++; $display("FAIL basic_period_start_p%0d: got first=%0d count=%0d expected first=1 count=1", p, ps_first, ps_cnt); end
            checks++; if (overlap !== 0) begin errors++; $display("FAIL basic_overlap_p%0d: got %0d expected 0", p, overlap); end
        end
    endtask

    task automatic test_duty_extremes();
        int hi, hi_n, ps_cnt, first_hi, overlap;
        bit ps_first, last_out;
        do_reset();
        start_run(7'd0);
        measure(1'b0, 128, 10, 7'd127, hi, hi_n, ps_cnt, ps_first, last_out, first_hi, overlap);
        checks++; if (hi !== 0) begin errors++; $display("FAIL duty0_high: got %0d expected 0", hi); end
        measure(1'b0, 128, -1, 7'd0, hi, hi_n, ps_cnt, ps_first, last_out, first_hi, overlap);
        checks++; if (hi !== 127 - DT) begin errors++; $display("FAIL duty127_high: got %0d expected %0d", hi, 127 - DT); end
        checks++; if (last_out !== 1'b0) begin errors++; $display("FAIL duty127_last_low: got %b expected 0", last_out); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL duty127_overlap: got %0d expected 0", overlap); end
    endtask

    task automatic test_duty_change();
        int hi, hi_n, ps_cnt, first_hi, overlap;
        bit ps_first, last_out;
        do_reset();
        start_run(7'd32);
        // index 9 is the sample where the counter holds 10
        measure(1'b0, 128, 9, 7'd64, hi, hi_n, ps_cnt, ps_first, last_out, first_hi, overlap);
        checks++; if (hi !== 32 - DT) begin errors++; $display("FAIL change_current: got %0d expected %0d", hi, 32 - DT); end
        measure(1'b0, 128, -1, 7'd0, hi, hi_n, ps_cnt, ps_first, last_out, first_hi, overlap);
        checks++; if (hi !== 64 - DT) begin errors++; $display("FAIL change_next: got %0d expected %0d", hi, 64 - DT); end
        checks++; if (!ps_first || ps_cnt !== 1) begin errors++; $display("FAIL change_period_start: got first=%0d count=%0d expected first=1 count=1", ps_first, ps_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_run(7'd64);
        for (int i = 0; i < 49; i++) step();
        checks++; if (dut.cnt_q !== 7'd50) begin errors++; $display("FAIL mid_cnt_before: got %0d expected 50", dut.cnt_q); end
        reset = 1'b1;
        step();
        checks++; if ({pwm_out, pwm_n, period_start} !== 3'b000) begin errors++; $display("FAIL mid_reset_outputs: got %b expected 000", {pwm_out, pwm_n, period_start}); end
        checks++; if (dut.cnt_q !== 7'd0) begin errors++; $display("FAIL mid_reset_cnt: got %0d expected 0", dut.cnt_q); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL mid_reset_state: got %0d expected IDLE", dut.state_q); end
        reset = 1'b0;
        step();
        step();
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL restart_period_start: got %b expected 1", period_start); end
        checks++; if (pwm_out !== (DT == 0)) begin errors++; $display("FAIL restart_pwm_out: got %b expected %b", pwm_out, DT == 0); end
    endtask

    task automatic test_prescale();
        int hi, hi_n, ps_cnt, first_hi, overlap;
        bit ps_first, last_out;
        reset3  = 1'b1;
        enable3 = 1'b0;
        duty3   = 7'd64;
        step();
        step();
        reset3  = 1'b0;
        enable3 = 1'b1;
        step();
        step();
        for (int p = 0; p < 2; p++) begin
            measure(1'b1, 384, -1, 7'd0, hi, hi_n, ps_cnt, ps_first, last_out, first_hi, overlap);
            checks++; if (hi !== 192 - DT) begin errors++; $display("FAIL presc3_high_p%0d: got %0d expected %0d", p, hi, 192 - DT); end
            checks++; if (!ps_first || ps_cnt !== 1) begin errors++; $display("FAIL presc3_period_start_p%0d: got first=%0d count=%0d expected first=1 count=1", p, ps_first, ps_cnt); end
            checks++; if (hi_n !== ((DT != 0) ? 192 - DT : 0)) begin errors++; $display("FAIL presc3_pwm_n_p%0d: got %0d expected %0d", p, hi_n, (DT != 0) ? 192 - DT : 0); end
        end
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        duty    = 7'd0;
        reset3  = 1'b1;
        enable3 = 1'b0;
        duty3   = 7'd0;
        test_reset();
        test_basic();
        test_duty_extremes();
        test_duty_change();
        test_reset_mid();
        test_prescale();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
